// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared definitions: stall encodings, bit indices,
// stall vector constants and FSM state encodings.
package pipe_ctrl_pkg;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam int STALL_W  = 6;
   localparam int STALL_PC = 0;
   localparam int STALL_IF = 1;
   localparam int STALL_ID = 2;
   localparam int STALL_EX = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB = 5;

   typedef logic [STALL_W-1:0] stall_t;

   localparam stall_t STALL_VEC_NONE = 6'b000000;
   localparam stall_t STALL_VEC_ID   = 6'b000111;
   localparam stall_t STALL_VEC_EX   = 6'b001111;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      ST_ID    = 2'd1,
      ST_EX    = 2'd2
   } state_e;

   // EX has priority; reset forces every register to advance.
   function automatic stall_t stall_vec(input logic rst,
                                        input logic id,
                                        input logic ex);
      stall_t v;
      v = STALL_VEC_NONE;
      unique case (1'b1)
         rst:              v = STALL_VEC_NONE;
         !rst && ex:       v = STALL_VEC_EX;
         !rst && !ex && id: v = STALL_VEC_ID;
         default:          v = STALL_VEC_NONE;
      endcase
      return v;
   endfunction

   function automatic state_e decode_state(input logic [1:0] s);
      state_e r;
      unique case (s)
         2'd1:    r = ST_ID;
         2'd2:    r = ST_EX;
         default: r = RUN;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall request / stall vector bundle between the pipeline
// stages (master) and the pipeline control unit (slave).
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic   stallreq_from_id;
   logic   stallreq_from_ex;
   stall_t stall;

   modport master (
      output stallreq_from_id,
      output stallreq_from_ex,
      input  stall
   );

   modport slave (
      input  stallreq_from_id,
      input  stallreq_from_ex,
      output stall
   );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear;
// holds at MAX once reached.
module pipe_ctrl_sat_counter #(
   parameter int             W   = 8,
   parameter logic [W-1:0]   MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall arbiter with stall-run watchdog.
// Define PIPE_CTRL_STATS_EN for saturating stall/bubble statistics.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_STALL = 255,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   pipe_ctrl_if.slave       bus,
   input  logic             err_clr_i,
   output logic [1:0]       state_o,
   output logic             stall_timeout_o,
`ifdef PIPE_CTRL_STATS_EN
   output logic             stall_err_o,
   output logic [CNT_W-1:0] stall_cnt_id_o,
   output logic [CNT_W-1:0] stall_cnt_ex_o,
   output logic [CNT_W-1:0] bubble_cnt_o
`else
   output logic             stall_err_o
`endif
);

   localparam int RL_W = $clog2(MAX_STALL + 1);

   if (MAX_STALL < 2 || CNT_W < 1) begin : g_bad_param
      $error("pipe_ctrl: MAX_STALL must be >= 2 and CNT_W >= 1");
   end

   logic      req_id;
   logic      req_ex;
   stall_t    stall_v;
   logic      stall_any;
   logic      trip;

   state_e    state_q;
   state_e    state_d;
   logic      timeout_q;
   logic      timeout_d;
   logic      err_q;
   logic      err_d;
   logic [RL_W-1:0] run_len_q;

   assign req_id    = bus.stallreq_from_id;
   assign req_ex    = bus.stallreq_from_ex;
   assign stall_v   = stall_vec(rst, req_id, req_ex);
   assign stall_any = |stall_v;
   assign bus.stall = stall_v;

   pipe_ctrl_sat_counter #(
      .W   (RL_W),
      .MAX (RL_W'(MAX_STALL))
   ) u_run_len (
      .clk   (clk),
      .rst   (rst),
      .clr_i (~stall_any),
      .en_i  (1'b1),
      .cnt_o (run_len_q)
   );

   // Trips only on the MAX-1 -> MAX step; saturation blocks re-trips.
   assign trip = stall_any && (run_len_q == RL_W'(MAX_STALL - 1));

   always_comb begin
      state_d   = RUN;
      timeout_d = trip;
      err_d     = err_q;
      unique case (1'b1)
         req_ex:            state_d = ST_EX;
         !req_ex && req_id: state_d = ST_ID;
         !req_ex && !req_id: state_d = RUN;
         default:           state_d = RUN;
      endcase
      if (trip) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         timeout_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
      end
   end

   assign state_o         = decode_state(state_q);
   assign stall_timeout_o = timeout_q;
   assign stall_err_o     = err_q;

`ifdef PIPE_CTRL_STATS_EN
   pipe_ctrl_sat_counter #(
      .W (CNT_W)
   ) u_cnt_id (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .en_i  (stall_any && !req_ex && req_id),
      .cnt_o (stall_cnt_id_o)
   );

   pipe_ctrl_sat_counter #(
      .W (CNT_W)
   ) u_cnt_ex (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .en_i  (stall_any && req_ex),
      .cnt_o (stall_cnt_ex_o)
   );

   pipe_ctrl_sat_counter #(
      .W (CNT_W)
   ) u_cnt_bub (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .en_i  (stall_any),
      .cnt_o (bubble_cnt_o)
   );
`endif

endmodule
